// File: rtl/barrier_tracker.sv
// Counts s_barrier arrivals per workgroup and pulses a wavefront release mask on completion.
// Accept -> lookup -> registered release (N+2); accepts at most every 2 cycles, held off through release.
module barrier_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        barrier_req,
  input  logic [5:0]  barrier_wfid,
  output logic        barrier_ready,
  output logic [5:0]  lookup_wfid,
  input  logic [5:0]  lookup_wgid,
  input  logic [3:0]  lookup_wf_count,
  input  logic        halt,
  input  logic [5:0]  halt_wfid,
  output logic        release_valid,
  output logic [5:0]  release_wgid,
  output logic [39:0] release_mask,
  output logic        dup_err
);

  localparam int NWF = 40;
  localparam int NWG = 64;

  typedef enum logic {IDLE, RELEASE} state_t;

  state_t      state, state_d;
  logic        s1_valid;
  logic [5:0]  s1_wfid;
  logic [39:0] arrived, arrived_d;
  logic [5:0]  wg_of [NWF];
  logic [3:0]  cnt [NWG];

  logic        halt_ok, halt_hit;
  logic [5:0]  halt_idx, halt_wg;
  logic        lk_ok, lk_dup, lk_new, complete;
  logic [5:0]  lk_idx;
  logic [4:0]  eff;
  logic [3:0]  cnt_cur;
  logic [39:0] mask_next;

  assign barrier_ready = (state == IDLE) && !s1_valid;
  // s1_wfid only changes on accept, so it already holds the last looked-up id.
  assign lookup_wfid   = s1_wfid;
  assign release_valid = (state == RELEASE);

  always_comb begin
    halt_ok  = halt && (halt_wfid < 6'd40);
    halt_idx = halt_ok ? halt_wfid : 6'd0;
    halt_hit = halt_ok && arrived[halt_idx];
    halt_wg  = wg_of[halt_idx];

    // A halt on the wavefront being looked up drops its arrival.
    lk_ok  = s1_valid && (s1_wfid < 6'd40) && !(halt_ok && (halt_wfid == s1_wfid));
    lk_idx = (s1_wfid < 6'd40) ? s1_wfid : 6'd0;
    lk_dup = lk_ok && arrived[lk_idx];
    lk_new = lk_ok && !arrived[lk_idx];

    eff      = (lookup_wf_count == 4'd0) ? 5'd1 : {1'b0, lookup_wf_count};
    cnt_cur  = cnt[lookup_wgid] - {3'b000, (halt_hit && (halt_wg == lookup_wgid))};
    complete = lk_new && (({1'b0, cnt_cur} + 5'd1) == eff);

    for (int i = 0; i < NWF; i++) begin
      mask_next[i] = (arrived[i] && (wg_of[i] == lookup_wgid) &&
                      !(halt_hit && (halt_idx == 6'(i)))) || (lk_idx == 6'(i));
    end

    arrived_d = arrived;
    if (halt_hit) arrived_d[halt_idx] = 1'b0;
    if (lk_new)   arrived_d[lk_idx]   = 1'b1;
    if (state == RELEASE) arrived_d = arrived_d & ~release_mask;

    state_d = state;
    case (state)
      IDLE:    if (complete) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      s1_valid     <= 1'b0;
      s1_wfid      <= 6'd0;
      arrived      <= '0;
      dup_err      <= 1'b0;
      release_wgid <= 6'd0;
      release_mask <= '0;
      for (int i = 0; i < NWF; i++) wg_of[i] <= 6'd0;
      for (int g = 0; g < NWG; g++) cnt[g] <= 4'd0;
    end else begin
      state   <= state_d;
      arrived <= arrived_d;

      if (barrier_req && barrier_ready) begin
        s1_valid <= 1'b1;
        s1_wfid  <= barrier_wfid;
      end else begin
        s1_valid <= 1'b0;
      end

      if (lk_dup) dup_err <= 1'b1;
      if (lk_new) wg_of[lk_idx] <= lookup_wgid;

      // Later writes win: arrival increment already accounts for a same-group halt,
      // and the release exit clear overrides any halt decrement on that group.
      if (halt_hit) cnt[halt_wg] <= cnt[halt_wg] - 4'd1;
      if (lk_new && !complete) cnt[lookup_wgid] <= cnt_cur + 4'd1;
      if (state == RELEASE) cnt[release_wgid] <= 4'd0;

      if (complete) begin
        release_mask <= mask_next;
        release_wgid <= lookup_wgid;
      end else begin
        release_mask <= '0;
        release_wgid <= 6'd0;
      end
    end
  end

endmodule

// File: tb/tb_barrier_tracker.sv
// Bench for barrier_tracker: directed table, multi-cycle corner cases, then random ops vs a set-based model.
module tb_barrier_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        barrier_req = 1'b0;
  logic [5:0]  barrier_wfid = 6'd0;
  logic        barrier_ready;
  logic [5:0]  lookup_wfid;
  logic [5:0]  lookup_wgid;
  logic [3:0]  lookup_wf_count;
  logic        halt = 1'b0;
  logic [5:0]  halt_wfid = 6'd0;
  logic        release_valid;
  logic [5:0]  release_wgid;
  logic [39:0] release_mask;
  logic        dup_err;

  logic [5:0] st_wg  [40];
  logic [3:0] st_cnt [40];

  int checks = 0;
  int errors = 0;

  assign lookup_wgid     = (lookup_wfid < 6'd40) ? st_wg[lookup_wfid]  : 6'd0;
  assign lookup_wf_count = (lookup_wfid < 6'd40) ? st_cnt[lookup_wfid] : 4'd0;

  barrier_tracker dut (
    .clk(clk), .rst(rst),
    .barrier_req(barrier_req), .barrier_wfid(barrier_wfid), .barrier_ready(barrier_ready),
    .lookup_wfid(lookup_wfid), .lookup_wgid(lookup_wgid), .lookup_wf_count(lookup_wf_count),
    .halt(halt), .halt_wfid(halt_wfid),
    .release_valid(release_valid), .release_wgid(release_wgid), .release_mask(release_mask),
    .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Issues one arrival; returns what the release outputs show in cycle N+2.
  task automatic arrive(input logic [5:0] w, input bit halt_in_lookup,
                        output bit v, output logic [5:0] g, output logic [39:0] m);
    int t;
    t = 0;
    @(negedge clk);
    while (!barrier_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!barrier_ready) chk("ready_timeout", 64'(barrier_ready), 64'd1);
    barrier_req  = 1'b1;
    barrier_wfid = w;
    @(negedge clk);
    barrier_req = 1'b0;
    chk("rv_n1", 64'(release_valid), 64'd0);
    chk("mask_n1", 64'(release_mask), 64'd0);
    if (halt_in_lookup) begin
      halt      = 1'b1;
      halt_wfid = w;
    end
    @(negedge clk);
    halt = 1'b0;
    v = release_valid;
    g = release_wgid;
    m = release_mask;
    @(negedge clk);
    chk("rv_n3", 64'(release_valid), 64'd0);
    chk("ready_n3", 64'(barrier_ready), 64'd1);
  endtask

  task automatic do_halt(input logic [5:0] w);
    @(negedge clk);
    halt      = 1'b1;
    halt_wfid = w;
    @(negedge clk);
    halt = 1'b0;
    chk("halt_rv", 64'(release_valid), 64'd0);
  endtask

  typedef struct {
    logic [5:0]  wfid;
    bit          rv;
    logic [5:0]  wg;
    logic [39:0] mask;
    bit          dup;
  } vec_t;

  vec_t tbl[12];

  bit [39:0] waiting [64];

  initial begin
    bit          v;
    logic [5:0]  g;
    logic [39:0] m;
    bit          dup_m;

    for (int i = 0; i < 40; i++) begin
      st_wg[i]  = 6'(i);
      st_cnt[i] = 4'd1;
    end
    for (int i = 8; i <= 10; i++) begin st_wg[i] = 6'd5; st_cnt[i] = 4'd3; end
    st_wg[2] = 6'd2;  st_cnt[2] = 4'd0;
    st_wg[0] = 6'd0;  st_cnt[0] = 4'd2;
    st_wg[1] = 6'd0;  st_cnt[1] = 4'd2;
    st_wg[20] = 6'd20; st_cnt[20] = 4'd2;
    st_wg[21] = 6'd20; st_cnt[21] = 4'd2;
    st_wg[30] = 6'd30; st_cnt[30] = 4'd2;
    st_wg[31] = 6'd30; st_cnt[31] = 4'd2;

    tbl[0]  = '{6'd8,  1'b0, 6'd0,  40'h0,         1'b0};
    tbl[1]  = '{6'd9,  1'b0, 6'd0,  40'h0,         1'b0};
    tbl[2]  = '{6'd10, 1'b1, 6'd5,  40'h700,       1'b0};
    tbl[3]  = '{6'd2,  1'b1, 6'd2,  40'h4,         1'b0};
    tbl[4]  = '{6'd0,  1'b0, 6'd0,  40'h0,         1'b0};
    tbl[5]  = '{6'd20, 1'b0, 6'd0,  40'h0,         1'b0};
    tbl[6]  = '{6'd21, 1'b1, 6'd20, 40'h30_0000,   1'b0};
    tbl[7]  = '{6'd1,  1'b1, 6'd0,  40'h3,         1'b0};
    tbl[8]  = '{6'd8,  1'b0, 6'd0,  40'h0,         1'b0};
    tbl[9]  = '{6'd8,  1'b0, 6'd0,  40'h0,         1'b1};
    tbl[10] = '{6'd9,  1'b0, 6'd0,  40'h0,         1'b1};
    tbl[11] = '{6'd10, 1'b1, 6'd5,  40'h700,       1'b1};

    // Reset values, sampled while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(barrier_ready), 64'd1);
    chk("rst_rv", 64'(release_valid), 64'd0);
    chk("rst_wgid", 64'(release_wgid), 64'd0);
    chk("rst_mask", 64'(release_mask), 64'd0);
    chk("rst_lookup", 64'(lookup_wfid), 64'd0);
    chk("rst_dup", 64'(dup_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 12; k++) begin
      arrive(tbl[k].wfid, 1'b0, v, g, m);
      chk($sformatf("tbl%0d_rv", k), 64'(v), 64'(tbl[k].rv));
      chk($sformatf("tbl%0d_wg", k), 64'(g), 64'(tbl[k].wg));
      chk($sformatf("tbl%0d_mask", k), 64'(m), 64'(tbl[k].mask));
      chk($sformatf("tbl%0d_dup", k), 64'(dup_err), 64'(tbl[k].dup));
    end

    // Halt removes an arrived member: 30, halt 30, 31 must not release; 30 again completes.
    arrive(6'd30, 1'b0, v, g, m);
    chk("h_30_rv", 64'(v), 64'd0);
    do_halt(6'd30);
    arrive(6'd31, 1'b0, v, g, m);
    chk("h_31_rv", 64'(v), 64'd0);
    arrive(6'd30, 1'b0, v, g, m);
    chk("h_30b_rv", 64'(v), 64'd1);
    chk("h_30b_mask", 64'(m), 64'hC000_0000);
    chk("h_30b_wg", 64'(g), 64'd30);

    // Halt in the lookup cycle of the same wavefront drops that arrival.
    arrive(6'd30, 1'b1, v, g, m);
    chk("hl_30_rv", 64'(v), 64'd0);
    arrive(6'd31, 1'b0, v, g, m);
    chk("hl_31_rv", 64'(v), 64'd0);
    arrive(6'd30, 1'b0, v, g, m);
    chk("hl_30b_rv", 64'(v), 64'd1);
    chk("hl_30b_mask", 64'(m), 64'hC000_0000);

    // Reset asserted during the release pulse.
    @(negedge clk);
    barrier_req  = 1'b1;
    barrier_wfid = 6'd2;
    @(negedge clk);
    barrier_req = 1'b0;
    @(negedge clk);
    chk("mr_rv_before", 64'(release_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("mr_rv", 64'(release_valid), 64'd0);
    chk("mr_mask", 64'(release_mask), 64'd0);
    chk("mr_wgid", 64'(release_wgid), 64'd0);
    chk("mr_dup", 64'(dup_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_ready", 64'(barrier_ready), 64'd1);
    arrive(6'd8, 1'b0, v, g, m);
    chk("mr_8_rv", 64'(v), 64'd0);

    // Random phase: fresh partition of wavefronts into workgroups.
    do_reset();
    begin
      int i, k, sz;
      i = 0;
      k = 0;
      while (i < 40) begin
        sz = $urandom_range(1, 4);
        if (sz > 40 - i) sz = 40 - i;
        for (int j = 0; j < sz; j++) begin
          st_wg[i + j]  = 6'((k * 7 + 3) % 64);
          st_cnt[i + j] = (sz == 1) ? 4'($urandom_range(0, 1)) : 4'(sz);
        end
        i += sz;
        k++;
      end
    end
    for (int g2 = 0; g2 < 64; g2++) waiting[g2] = '0;
    dup_m = 1'b0;

    for (int n = 0; n < 250; n++) begin
      logic [5:0]  w, eg;
      int          eff;
      bit          ev;
      logic [39:0] em;
      w = 6'($urandom_range(0, 39));
      eg = st_wg[w];
      if ($urandom_range(0, 9) < 3) begin
        waiting[eg][w] = 1'b0;
        do_halt(w);
      end else begin
        eff = (st_cnt[w] == 4'd0) ? 1 : int'(st_cnt[w]);
        ev = 1'b0;
        em = '0;
        if (waiting[eg][w]) begin
          dup_m = 1'b1;
        end else begin
          waiting[eg][w] = 1'b1;
          if ($countones(waiting[eg]) == eff) begin
            ev = 1'b1;
            em = waiting[eg];
            waiting[eg] = '0;
          end
        end
        arrive(w, 1'b0, v, g, m);
        chk($sformatf("rnd%0d_rv", n), 64'(v), 64'(ev));
        chk($sformatf("rnd%0d_wg", n), 64'(g), ev ? 64'(eg) : 64'd0);
        chk($sformatf("rnd%0d_mask", n), 64'(m), 64'(em));
        chk($sformatf("rnd%0d_dup", n), 64'(dup_err), 64'(dup_m));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
